// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ADD/SUB/logic/shift ops and a WIDTH-cycle shift-add MUL.
// The result is registered and held until the consumer takes it.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               cflag,
    output logic               zflag
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam logic [RW-1:0] SHIFT_LIMIT = RW'(RW);
    localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [RW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     result_q, result_d;
    logic              cflag_q, cflag_d;
    logic              zflag_q, zflag_d;

    logic [RW-1:0]     a_ext, b_ext, alu_res, acc_step;
    logic [WIDTH-1:0]  diff;
    logic              alu_c, accept, mul_last;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (opcode == OP_MUL) ? BUSY : DONE;
            BUSY:    if (mul_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign accept   = in_valid && in_ready;
    assign mul_last = (state_q == BUSY) && (cnt_q == CNT_LAST);

    always_comb begin
        a_ext   = {{WIDTH{1'b0}}, operand1};
        b_ext   = {{WIDTH{1'b0}}, operand2};
        diff    = operand1 - operand2;
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = {{WIDTH{1'b0}}, diff};
            OP_OR:   alu_res = a_ext | b_ext;
            OP_AND:  alu_res = a_ext & b_ext;
            OP_XOR:  alu_res = a_ext ^ b_ext;
            OP_SHL:  alu_res = (b_ext >= SHIFT_LIMIT) ? '0 : (a_ext << operand2);
            OP_SHR:  alu_res = (b_ext >= SHIFT_LIMIT) ? '0 : (a_ext >> operand2);
            default: alu_res = '0;
        endcase
        // SUB reports borrow; every other op reports anything that spilled into the upper half
        alu_c = (opcode == OP_SUB) ? (operand1 < operand2) : |alu_res[RW-1:WIDTH];
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cflag_d  = cflag_q;
        zflag_d  = zflag_q;
        if (accept) begin
            if (opcode == OP_MUL) begin
                acc_d    = '0;
                mcand_d  = a_ext;
                mplier_d = operand2;
                cnt_d    = '0;
            end else begin
                result_d = alu_res;
                cflag_d  = alu_c;
                zflag_d  = (alu_res == '0);
            end
        end else if (state_q == BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (mul_last) begin
                result_d = acc_step;
                cflag_d  = |acc_step[RW-1:WIDTH];
                zflag_d  = (acc_step == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cflag_q  <= 1'b0;
            zflag_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cflag_q  <= cflag_d;
            zflag_q  <= zflag_d;
        end
    end

    assign result = result_q;
    assign cflag  = cflag_q;
    assign zflag  = zflag_q;

endmodule
